// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use stall detection.
// Two forwarding muxes (rs1, rs2) sit behind the register and feed the ALU operands.

module id_ex_fwd_mux #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] src_rs,
  input  logic [DATA_WIDTH-1:0]     reg_data,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic                      exmem_reg_write,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic                      memwb_reg_write,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic [DATA_WIDTH-1:0]     fwd_data
);
  // Newest producer first; x0 is hardwired zero and never forwarded.
  always_comb begin
    fwd_data = reg_data;
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == src_rs)
      fwd_data = exmem_result;
    else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == src_rs)
      fwd_data = memwb_result;
  end
endmodule

module id_ex_forward_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALU_OP_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_i,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data_i,
  input  logic [DATA_WIDTH-1:0]     id_imm_i,
  input  logic [ALU_OP_WIDTH-1:0]   id_alu_op_i,
  input  logic                      id_alu_src_i,
  input  logic                      id_reg_write_i,
  input  logic                      id_mem_read_i,
  input  logic                      flush_i,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_i,
  input  logic                      exmem_reg_write_i,
  input  logic [DATA_WIDTH-1:0]     exmem_result_i,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_i,
  input  logic                      memwb_reg_write_i,
  input  logic [DATA_WIDTH-1:0]     memwb_result_i,
  output logic                      stall_o,
  output logic                      ex_valid_o,
  output logic [ALU_OP_WIDTH-1:0]   alu_op_o,
  output logic [DATA_WIDTH-1:0]     alu_a_o,
  output logic [DATA_WIDTH-1:0]     alu_b_o,
  output logic [DATA_WIDTH-1:0]     ex_store_data_o,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd_o,
  output logic                      ex_reg_write_o,
  output logic                      ex_mem_read_o
);
  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic [ALU_OP_WIDTH-1:0]   alu_op;
    logic                      alu_src;
    logic                      reg_write;
    logic                      mem_read;
  } idex_t;

  idex_t ex_q, ex_d;

  assign stall_o = ex_q.valid && ex_q.mem_read && ex_q.rd != '0 && id_valid_i &&
                   (ex_q.rd == id_rs1_i || ex_q.rd == id_rs2_i);

  // Flush and stall both leave an all-zero bubble; the stalled instruction stays in ID.
  always_comb begin
    ex_d = '0;
    if (!(flush_i || stall_o)) begin
      ex_d.valid     = id_valid_i;
      ex_d.rs1       = id_rs1_i;
      ex_d.rs2       = id_rs2_i;
      ex_d.rd        = id_rd_i;
      ex_d.rs1_data  = id_rs1_data_i;
      ex_d.rs2_data  = id_rs2_data_i;
      ex_d.imm       = id_imm_i;
      ex_d.alu_op    = id_alu_op_i;
      ex_d.alu_src   = id_alu_src_i;
      ex_d.reg_write = id_reg_write_i && id_valid_i;
      ex_d.mem_read  = id_mem_read_i && id_valid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  // Index 0 = rs1, index 1 = rs2.
  logic [1:0][REG_ADDR_WIDTH-1:0] src_rs;
  logic [1:0][DATA_WIDTH-1:0]     src_data;
  logic [1:0][DATA_WIDTH-1:0]     fwd_data;

  assign src_rs   = {ex_q.rs2, ex_q.rs1};
  assign src_data = {ex_q.rs2_data, ex_q.rs1_data};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    id_ex_fwd_mux #(
      .DATA_WIDTH    (DATA_WIDTH),
      .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_mux (
      .src_rs         (src_rs[g]),
      .reg_data       (src_data[g]),
      .exmem_rd       (exmem_rd_i),
      .exmem_reg_write(exmem_reg_write_i),
      .exmem_result   (exmem_result_i),
      .memwb_rd       (memwb_rd_i),
      .memwb_reg_write(memwb_reg_write_i),
      .memwb_result   (memwb_result_i),
      .fwd_data       (fwd_data[g])
    );
  end

  assign alu_a_o         = fwd_data[0];
  assign alu_b_o         = ex_q.alu_src ? ex_q.imm : fwd_data[1];
  assign ex_store_data_o = fwd_data[1];
  assign ex_valid_o      = ex_q.valid;
  assign alu_op_o        = ex_q.alu_op;
  assign ex_rd_o         = ex_q.rd;
  assign ex_reg_write_o  = ex_q.reg_write;
  assign ex_mem_read_o   = ex_q.mem_read;
endmodule

// File: tb/tb_id_ex_forward_stage.sv
// Bench for id_ex_forward_stage: directed literal checks, then randomized traffic
// compared every cycle against a record-of-last-issued-instruction model.
module tb_id_ex_forward_stage;
  logic        clk = 0;
  logic        reset;
  logic        id_valid_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [3:0]  id_alu_op_i;
  logic        id_alu_src_i, id_reg_write_i, id_mem_read_i, flush_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic        exmem_reg_write_i, memwb_reg_write_i;
  logic [31:0] exmem_result_i, memwb_result_i;
  logic        stall_o, ex_valid_o, ex_reg_write_o, ex_mem_read_o;
  logic [3:0]  alu_op_o;
  logic [31:0] alu_a_o, alu_b_o, ex_store_data_o;
  logic [4:0]  ex_rd_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ex_forward_stage dut (
    .clk(clk), .reset(reset), .id_valid_i(id_valid_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
    .id_alu_op_i(id_alu_op_i), .id_alu_src_i(id_alu_src_i),
    .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i), .flush_i(flush_i),
    .exmem_rd_i(exmem_rd_i), .exmem_reg_write_i(exmem_reg_write_i), .exmem_result_i(exmem_result_i),
    .memwb_rd_i(memwb_rd_i), .memwb_reg_write_i(memwb_reg_write_i), .memwb_result_i(memwb_result_i),
    .stall_o(stall_o), .ex_valid_o(ex_valid_o), .alu_op_o(alu_op_o),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .ex_store_data_o(ex_store_data_o),
    .ex_rd_o(ex_rd_o), .ex_reg_write_o(ex_reg_write_o), .ex_mem_read_o(ex_mem_read_o)
  );

  // Model: the instruction currently sitting in EX, or an all-zero bubble.
  typedef struct {
    bit        valid, src, we, mr;
    bit [4:0]  rs1, rs2, rd;
    bit [31:0] d1, d2, imm;
    bit [3:0]  op;
  } inst_t;
  inst_t m;

  function automatic bit model_stall();
    return m.valid && m.mr && m.rd != 0 && id_valid_i &&
           (m.rd == id_rs1_i || m.rd == id_rs2_i);
  endfunction

  // Value an EX source must see: newest in-flight writer of that register, else the file read.
  function automatic logic [31:0] operand(input bit [4:0] r, input bit [31:0] file_val);
    if (r == 0) return file_val;
    if (exmem_reg_write_i && exmem_rd_i == r) return exmem_result_i;
    if (memwb_reg_write_i && memwb_rd_i == r) return memwb_result_i;
    return file_val;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cmp_model();
    logic [31:0] b2;
    b2 = operand(m.rs2, m.d2);
    chk("m_stall", {31'b0, stall_o}, {31'b0, model_stall()});
    chk("m_valid", {31'b0, ex_valid_o}, {31'b0, m.valid});
    chk("m_op", {28'b0, alu_op_o}, {28'b0, m.op});
    chk("m_a", alu_a_o, operand(m.rs1, m.d1));
    chk("m_b", alu_b_o, m.src ? m.imm : b2);
    chk("m_store", ex_store_data_o, b2);
    chk("m_rd", {27'b0, ex_rd_o}, {27'b0, m.rd});
    chk("m_we", {31'b0, ex_reg_write_o}, {31'b0, m.we});
    chk("m_mr", {31'b0, ex_mem_read_o}, {31'b0, m.mr});
  endtask

  task automatic tick();
    bit st;
    @(posedge clk);
    st = model_stall();
    if (reset || flush_i || st) m = '{default: 0};
    else begin
      m.valid = id_valid_i; m.rs1 = id_rs1_i; m.rs2 = id_rs2_i; m.rd = id_rd_i;
      m.d1 = id_rs1_data_i; m.d2 = id_rs2_data_i; m.imm = id_imm_i; m.op = id_alu_op_i;
      m.src = id_alu_src_i; m.we = id_reg_write_i && id_valid_i; m.mr = id_mem_read_i && id_valid_i;
    end
    #1;
  endtask

  task automatic idle();
    id_valid_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_rd_i = 0;
    id_rs1_data_i = 0; id_rs2_data_i = 0; id_imm_i = 0; id_alu_op_i = 0;
    id_alu_src_i = 0; id_reg_write_i = 0; id_mem_read_i = 0; flush_i = 0;
    exmem_rd_i = 0; exmem_reg_write_i = 0; exmem_result_i = 0;
    memwb_rd_i = 0; memwb_reg_write_i = 0; memwb_result_i = 0;
  endtask

  task automatic rand_id();
    id_valid_i = ($urandom_range(0, 3) != 0);
    id_rs1_i = 5'($urandom_range(0, 7)); id_rs2_i = 5'($urandom_range(0, 7));
    id_rd_i = 5'($urandom_range(0, 7));
    id_rs1_data_i = $urandom; id_rs2_data_i = $urandom; id_imm_i = $urandom;
    id_alu_op_i = 4'($urandom); id_alu_src_i = 1'($urandom);
    id_reg_write_i = 1'($urandom); id_mem_read_i = ($urandom_range(0, 2) == 0);
  endtask

  task automatic set_inst(input bit [4:0] rs1, input bit [31:0] d1, input bit [4:0] rs2,
                          input bit [31:0] d2, input bit [4:0] rd, input bit [3:0] op,
                          input bit src, input bit [31:0] imm, input bit we, input bit mr);
    id_valid_i = 1; id_rs1_i = rs1; id_rs1_data_i = d1; id_rs2_i = rs2; id_rs2_data_i = d2;
    id_rd_i = rd; id_alu_op_i = op; id_alu_src_i = src; id_imm_i = imm;
    id_reg_write_i = we; id_mem_read_i = mr;
  endtask

  initial begin
    m = '{default: 0};
    idle();
    reset = 1;
    #1;
    // Reset held two cycles with live ID traffic
    rand_id(); tick(); rand_id(); tick();
    #1;
    chk("rst_valid", {31'b0, ex_valid_o}, 0);
    chk("rst_a", alu_a_o, 0);
    chk("rst_b", alu_b_o, 0);
    chk("rst_stall", {31'b0, stall_o}, 0);
    chk("rst_we", {31'b0, ex_reg_write_o}, 0);
    cmp_model();

    // Pass-through
    reset = 0;
    set_inst(3, 32'h10, 4, 32'h20, 6, 4'b0001, 0, 0, 1, 0);
    tick(); idle(); #1;
    chk("pt_a", alu_a_o, 32'h10);
    chk("pt_b", alu_b_o, 32'h20);
    chk("pt_op", {28'b0, alu_op_o}, 32'h1);
    chk("pt_valid", {31'b0, ex_valid_o}, 1);
    cmp_model();

    // Immediate operand
    set_inst(3, 32'h10, 4, 32'h20, 6, 4'b0010, 1, 32'h0000_0ABC, 1, 0);
    tick(); idle(); #1;
    chk("imm_b", alu_b_o, 32'hABC);
    chk("imm_store", ex_store_data_o, 32'h20);
    cmp_model();

    // Forwarding priority on rs1=5
    set_inst(5, 32'h55, 0, 0, 8, 4'b0000, 0, 0, 1, 0);
    tick(); idle();
    exmem_rd_i = 5; exmem_reg_write_i = 1; exmem_result_i = 32'hAAAA;
    memwb_rd_i = 5; memwb_reg_write_i = 1; memwb_result_i = 32'hBBBB;
    #1; chk("fwd_exmem", alu_a_o, 32'hAAAA); cmp_model();
    exmem_reg_write_i = 0;
    #1; chk("fwd_memwb", alu_a_o, 32'hBBBB); cmp_model();
    exmem_reg_write_i = 1; exmem_rd_i = 0; memwb_rd_i = 0;
    #1; chk("fwd_x0", alu_a_o, 32'h55); cmp_model();

    // Load-use: load rd=7 then consumer on rs2=7
    idle();
    set_inst(1, 32'h100, 0, 0, 7, 4'b0000, 0, 32'h4, 1, 1);
    tick();
    set_inst(1, 32'h1, 7, 32'hDEAD, 9, 4'b0011, 0, 0, 1, 0);
    #1; chk("lu_stall", {31'b0, stall_o}, 1); cmp_model();
    tick();
    #1;
    chk("lu_bubble_valid", {31'b0, ex_valid_o}, 0);
    chk("lu_bubble_op", {28'b0, alu_op_o}, 0);
    chk("lu_unstall", {31'b0, stall_o}, 0);
    cmp_model();
    tick();
    memwb_rd_i = 7; memwb_reg_write_i = 1; memwb_result_i = 32'h77;
    id_valid_i = 0;
    #1;
    chk("lu_fwd_b", alu_b_o, 32'h77);
    chk("lu_op", {28'b0, alu_op_o}, 32'h3);
    cmp_model();

    // Flush of a valid add
    idle();
    set_inst(1, 1, 2, 2, 10, 4'b0000, 0, 0, 1, 0);
    flush_i = 1;
    tick(); idle(); #1;
    chk("fl_valid", {31'b0, ex_valid_o}, 0);
    chk("fl_we", {31'b0, ex_reg_write_o}, 0);
    cmp_model();

    // Flush together with stall
    set_inst(1, 0, 0, 0, 9, 4'b0000, 0, 0, 1, 1);
    tick();
    set_inst(9, 0, 2, 0, 11, 4'b0101, 0, 0, 1, 0);
    flush_i = 1;
    #1; chk("fs_stall", {31'b0, stall_o}, 1); cmp_model();
    tick(); idle(); #1;
    chk("fs_valid", {31'b0, ex_valid_o}, 0);
    chk("fs_op", {28'b0, alu_op_o}, 0);
    cmp_model();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_id();
      reset = ($urandom_range(0, 49) == 0);
      flush_i = ($urandom_range(0, 7) == 0);
      exmem_rd_i = 5'($urandom_range(0, 7)); exmem_reg_write_i = 1'($urandom);
      exmem_result_i = $urandom;
      memwb_rd_i = 5'($urandom_range(0, 7)); memwb_reg_write_i = 1'($urandom);
      memwb_result_i = $urandom;
      #1; cmp_model();
      tick();
    end
    reset = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/id_ex_forward_stage.md
Name: id_ex_forward_stage

Overview:
- ID/EX pipeline register plus operand-forwarding and load-use hazard logic for the 5-stage RISC-V pipeline.
- Captures decoded fields from ID on each clock.
- Resolves RAW hazards by selecting the newest value from EX/MEM or MEM/WB.
- Drives operand and opcode inputs of the EX-stage ALU (4-bit operation code, two signed 32-bit operands); requests a one-cycle ID stall on load-use.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- REG_ADDR_WIDTH, 5, register index width.
- ALU_OP_WIDTH, 4, ALU operation code width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- id_valid_i  input  1  ID slot holds a real instruction.
- id_rs1_i / id_rs2_i / id_rd_i  input  5 each  source/destination indices.
- id_rs1_data_i / id_rs2_data_i  input  32 each  register-file read data.
- id_imm_i  input  32  immediate, passed through unchanged.
- id_alu_op_i  input  4  ALU operation code.
- id_alu_src_i  input  1  1 = operand B is the immediate.
- id_reg_write_i / id_mem_read_i  input  1 each  writeback enable / load.
- flush_i  input  1  squash instruction entering EX (branch taken).
- exmem_rd_i, exmem_reg_write_i, exmem_result_i  input  5/1/32  EX/MEM producer.
- memwb_rd_i, memwb_reg_write_i, memwb_result_i  input  5/1/32  MEM/WB producer.
- stall_o  output  1  hold PC and IF/ID this cycle.
- ex_valid_o  output  1  EX slot valid.
- alu_op_o  output  4  to ALU operation input.
- alu_a_o / alu_b_o  output  32 each  to ALU A/B operands.
- ex_store_data_o  output  32  forwarded rs2 (store data).
- ex_rd_o, ex_reg_write_o, ex_mem_read_o  output  5/1/1  control passed downstream.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on the port named reset.
- Reset state: all registered fields are 0.
  - ex_valid_o=0, alu_op_o=0, ex_rd_o=0, ex_reg_write_o=0, ex_mem_read_o=0.
  - alu_a_o=alu_b_o=ex_store_data_o=0.
  - stall_o=0.
- Latency: ID→EX is exactly 1 cycle. Forwarding and stall_o are combinational from registered state and current inputs.
- Load-use stall:
  - stall_o = ex_valid & ex_mem_read & (ex_rd≠0) & id_valid_i & (ex_rd==id_rs1_i | ex_rd==id_rs2_i).
  - Both sources are compared regardless of id_alu_src_i.
- Register update at each posedge, priority reset > flush_i > stall_o > capture:
  - flush_i or stall_o: insert a bubble. All fields are cleared to 0, so valid=0, reg_write=0, mem_read=0, alu_op=0 and rd/rs=0.
  - Capture: all id_* fields are loaded. valid=id_valid_i. reg_write and mem_read are ANDed with id_valid_i.
  - flush_i and stall_o together: bubble, as for flush. Upstream ignores the stall when flushing.
- Forwarding, rs1 (rs2 identical):
  - EX/MEM hit: exmem_reg_write_i & exmem_rd_i≠0 & exmem_rd_i==ex_rs1 → exmem_result_i.
  - Else MEM/WB hit: the same test on memwb_* → memwb_result_i.
  - Else the registered rs1 data.
  - EX/MEM has priority over MEM/WB on a double hit (newest value wins).
  - Register x0 is never forwarded.
- Operand selection:
  - alu_a_o = forwarded rs1.
  - alu_b_o = id_alu_src ? registered imm : forwarded rs2.
  - ex_store_data_o = forwarded rs2 always.
- Bubbles and invalid slots:
  - A bubble has rs1=rs2=0, so no forwarding occurs and the ALU sees 0 op 0.
  - An invalid slot never produces a write or load downstream.
- Stall scope: a stall holds nothing in EX. The EX slot advances and becomes a bubble; ID re-presents the same instruction next cycle. A load-use therefore costs exactly 1 bubble.
- Reset mid-stall: stall_o deasserts the cycle after reset, because ex_mem_read becomes 0.

Test Plan:
- Reset: assert reset 2 cycles with random ID inputs → all outputs 0, stall_o=0. Release reset → the first captured instruction appears 1 cycle later.
- Pass-through: id rs1=3 (data 0x10), rs2=4 (data 0x20), alu_src=0, op=0001, no producer hits → next cycle alu_a_o=0x10, alu_b_o=0x20, alu_op_o=0001, ex_valid_o=1.
- Immediate: alu_src=1, imm=0x0000_0ABC → alu_b_o=0xABC, ex_store_data_o=forwarded rs2.
- Forwarding priority:
  - EX rs1=5 with exmem rd=5/res=0xAAAA and memwb rd=5/res=0xBBBB → alu_a_o=0xAAAA.
  - Drop exmem_reg_write → alu_a_o=0xBBBB.
  - With rd=0 instead → registered data.
- Load-use: EX holds a load to rd=7; ID presents rs2=7 → stall_o=1 that cycle. Next cycle ex_valid_o=0 with alu_op_o=0. ID re-presents → captured, and the value is forwarded from MEM/WB.
- Flush: flush_i=1 with a valid ID add (reg_write=1) → next cycle ex_valid_o=0, ex_reg_write_o=0. Flush and stall together → same bubble.
